// File: rtl/bin2seg_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with registered
// active-low seven-segment drive, overflow detection and optional leading-zero blanking.
module bin2seg_seq #(
    parameter int IN_W     = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    input  logic [IN_W-1:0]     in_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [7*DIGITS-1:0] seg_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(IN_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q;
    logic [IN_W-1:0]   shiftReg_q;
    logic [BW-1:0]     scratch_q;
    logic [CW-1:0]     count_q;
    logic              ovf_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;
    logic [BW-1:0]     bcd_q;
    logic [7*DIGITS-1:0] seg_q;

    logic [BW-1:0]       adjusted_d;
    logic [BW-1:0]       scratch_d;
    logic [IN_W-1:0]     shiftReg_d;
    logic                ovf_d;
    logic [7*DIGITS-1:0] seg_d;

    function automatic logic [6:0] glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Walk from the top digit down; once a nonzero digit (or digit 0) is reached, all lower digits are lit.
    function automatic logic [7*DIGITS-1:0] encodeSeg(input logic [BW-1:0] digits, input logic ovf);
        logic [7*DIGITS-1:0] seg;
        logic                lit;
        seg = '0;
        lit = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (!BLANK_LZ || k == 0 || digits[4*k +: 4] != 4'd0) begin
                lit = 1'b1;
            end
            if (ovf) begin
                seg[7*k +: 7] = 7'h3F;
            end else if (!lit) begin
                seg[7*k +: 7] = 7'h7F;
            end else begin
                seg[7*k +: 7] = ~glyph(digits[4*k +: 4]);
            end
        end
        return seg;
    endfunction

    // One double-dabble step; a set MSB in the top digit is about to leave the register, so it is an overflow.
    always_comb begin
        adjusted_d = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adjusted_d[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
        scratch_d  = {adjusted_d[BW-2:0], shiftReg_q[IN_W-1]};
        shiftReg_d = shiftReg_q << 1;
        ovf_d      = ovf_q | adjusted_d[BW-1];
        seg_d      = encodeSeg(scratch_d, ovf_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            seg_q      <= encodeSeg('0, 1'b0);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shiftReg_q <= in_i;
                        scratch_q  <= '0;
                        count_q    <= '0;
                        ovf_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shiftReg_q <= shiftReg_d;
                    scratch_q  <= scratch_d;
                    ovf_q      <= ovf_d;
                    count_q    <= count_q + CW'(1);
                    if (count_q == LAST_STEP) begin
                        bcd_q      <= scratch_d;
                        seg_q      <= seg_d;
                        overflow_q <= ovf_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign bcd_o      = bcd_q;
    assign seg_o      = seg_q;

endmodule

// File: tb/tb_bin2seg_seq.sv
// Testbench for bin2seg_seq: three instances (5 digits blanked, 5 digits unblanked, 4 digits
// blanked) share one stimulus stream and are compared against an arithmetic decimal model.
module tb_bin2seg_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] inVal = '0;

    logic        busyA, doneA, ovfA;
    logic [19:0] bcdA;
    logic [34:0] segA;
    logic        busyB, doneB, ovfB;
    logic [19:0] bcdB;
    logic [34:0] segB;
    logic        busyC, doneC, ovfC;
    logic [15:0] bcdC;
    logic [27:0] segC;

    int checks = 0;
    int passes = 0;

    localparam logic [7:0] GLYPHS [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    bin2seg_seq #(.IN_W(16), .DIGITS(5), .BLANK_LZ(1'b1)) dutA (
        .clk(clk), .reset_n(reset_n), .start_i(start), .in_i(inVal),
        .busy_o(busyA), .done_o(doneA), .overflow_o(ovfA), .bcd_o(bcdA), .seg_o(segA));

    bin2seg_seq #(.IN_W(16), .DIGITS(5), .BLANK_LZ(1'b0)) dutB (
        .clk(clk), .reset_n(reset_n), .start_i(start), .in_i(inVal),
        .busy_o(busyB), .done_o(doneB), .overflow_o(ovfB), .bcd_o(bcdB), .seg_o(segB));

    bin2seg_seq #(.IN_W(16), .DIGITS(4), .BLANK_LZ(1'b1)) dutC (
        .clk(clk), .reset_n(reset_n), .start_i(start), .in_i(inVal),
        .busy_o(busyC), .done_o(doneC), .overflow_o(ovfC), .bcd_o(bcdC), .seg_o(segC));

    always #5 clk = ~clk;

    // Decimal reference: digits by repeated division, display rules applied per digit.
    function automatic logic [19:0] modelBcd(input longint v, input int nd);
        logic [19:0] r;
        longint      pw;
        r  = '0;
        pw = 1;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'((v / pw) % 10);
            pw = pw * 10;
        end
        return r;
    endfunction

    function automatic logic modelOvf(input longint v, input int nd);
        longint lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    function automatic logic [34:0] modelSeg(input longint v, input int nd, input bit blank);
        logic [34:0] r;
        logic [7:0]  g;
        longint      pw;
        int          msd;
        int          d;
        r   = '0;
        msd = 0;
        pw  = 1;
        for (int k = 0; k < nd; k++) begin
            if ((v / pw) % 10 != 0) msd = k;
            pw = pw * 10;
        end
        pw = 1;
        for (int k = 0; k < nd; k++) begin
            d = int'((v / pw) % 10);
            g = ~GLYPHS[d];
            if (modelOvf(v, nd))       r[7*k +: 7] = 7'h3F;
            else if (blank && k > msd) r[7*k +: 7] = 7'h7F;
            else                       r[7*k +: 7] = g[6:0];
            pw = pw * 10;
        end
        return r;
    endfunction

    task automatic doConvert(input logic [15:0] value, output int latency,
                             output int busyHigh, output logic busyAtDone);
        @(negedge clk);
        start = 1'b1;
        inVal = value;
        @(posedge clk);
        #1;
        start      = 1'b0;
        inVal      = 16'($urandom);
        busyHigh   = busyA ? 1 : 0;
        busyAtDone = 1'b1;
        latency    = 0;
        while (latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
            if (doneA) begin
                busyAtDone = busyA;
                break;
            end
            if (busyA) busyHigh++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busyA !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busyA); else passes++;
        checks++; if (doneA !== 1'b0) $display("FAIL reset_done: got %b expected 0", doneA); else passes++;
        checks++; if (ovfA !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovfA); else passes++;
        checks++; if (bcdA !== 20'h0) $display("FAIL reset_bcd: got %h expected 0", bcdA); else passes++;
        checks++; if (segA !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL reset_segA: got %h expected %h", segA, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); else passes++;
        checks++; if (segB !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h40})
            $display("FAIL reset_segB: got %h expected %h", segB, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}); else passes++;
        checks++; if (segC !== {7'h7F, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL reset_segC: got %h expected %h", segC, {7'h7F, 7'h7F, 7'h7F, 7'h40}); else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busyA !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busyA); else passes++;
    endtask

    task automatic test_zero;
        int lat, bh;
        logic bd;
        doConvert(16'd0, lat, bh, bd);
        checks++; if (lat !== 16) $display("FAIL zero_latency: got %0d expected 16", lat); else passes++;
        checks++; if (bcdA !== 20'h0) $display("FAIL zero_bcd: got %h expected 0", bcdA); else passes++;
        checks++; if (segA !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL zero_seg: got %h expected %h", segA, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); else passes++;
        checks++; if (ovfA !== 1'b0) $display("FAIL zero_ovf: got %b expected 0", ovfA); else passes++;
        checks++; if (doneC !== 1'b1) $display("FAIL zero_doneC: got %b expected 1", doneC); else passes++;
        @(posedge clk);
        #1;
        checks++; if (doneA !== 1'b0) $display("FAIL done_width: got %b expected 0", doneA); else passes++;
    endtask

    task automatic test_max;
        int lat, bh;
        logic bd;
        doConvert(16'd65535, lat, bh, bd);
        checks++; if (lat !== 16) $display("FAIL max_latency: got %0d expected 16", lat); else passes++;
        checks++; if (bh !== 16) $display("FAIL max_busy_cycles: got %0d expected 16", bh); else passes++;
        checks++; if (bd !== 1'b0) $display("FAIL max_busy_at_done: got %b expected 0", bd); else passes++;
        checks++; if (bcdA !== 20'h65535) $display("FAIL max_bcd: got %h expected 65535", bcdA); else passes++;
        checks++; if (segA !== {7'h02, 7'h12, 7'h12, 7'h30, 7'h12})
            $display("FAIL max_seg: got %h expected %h", segA, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}); else passes++;
        checks++; if (ovfC !== 1'b1) $display("FAIL max_ovfC: got %b expected 1", ovfC); else passes++;
        checks++; if (bcdC !== 16'h5535) $display("FAIL max_bcdC: got %h expected 5535", bcdC); else passes++;
        checks++; if (segC !== {4{7'h3F}}) $display("FAIL max_segC: got %h expected %h", segC, {4{7'h3F}}); else passes++;
    endtask

    task automatic test_blanking;
        int lat, bh;
        logic bd;
        doConvert(16'd1234, lat, bh, bd);
        checks++; if (segA !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19})
            $display("FAIL blank_segA: got %h expected %h", segA, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}); else passes++;
        checks++; if (segB !== {7'h40, 7'h79, 7'h24, 7'h30, 7'h19})
            $display("FAIL blank_segB: got %h expected %h", segB, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19}); else passes++;
        checks++; if (bcdB !== 20'h01234) $display("FAIL blank_bcdB: got %h expected 01234", bcdB); else passes++;
    endtask

    task automatic test_overflow;
        int lat, bh;
        logic bd;
        doConvert(16'd10000, lat, bh, bd);
        checks++; if (ovfC !== 1'b1) $display("FAIL ovf_flagC: got %b expected 1", ovfC); else passes++;
        checks++; if (segC !== {4{7'h3F}}) $display("FAIL ovf_segC: got %h expected %h", segC, {4{7'h3F}}); else passes++;
        checks++; if (bcdC !== 16'h0000) $display("FAIL ovf_bcdC: got %h expected 0000", bcdC); else passes++;
        checks++; if (ovfA !== 1'b0) $display("FAIL ovf_flagA: got %b expected 0", ovfA); else passes++;
        checks++; if (segA !== {7'h79, 7'h40, 7'h40, 7'h40, 7'h40})
            $display("FAIL ovf_segA: got %h expected %h", segA, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}); else passes++;
        doConvert(16'd9999, lat, bh, bd);
        checks++; if (ovfC !== 1'b0) $display("FAIL nines_ovfC: got %b expected 0", ovfC); else passes++;
        checks++; if (segC !== {4{7'h10}}) $display("FAIL nines_segC: got %h expected %h", segC, {4{7'h10}}); else passes++;
        checks++; if (bcdC !== 16'h9999) $display("FAIL nines_bcdC: got %h expected 9999", bcdC); else passes++;
    endtask

    task automatic test_random;
        int lat, bh;
        logic bd;
        logic [15:0] value;
        logic [19:0] expBcd;
        logic [34:0] expSeg;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) value = 16'($urandom_range(9990, 10010));
            else if (i % 3 == 1) value = 16'($urandom_range(0, 999));
            else value = 16'($urandom_range(0, 65535));
            doConvert(value, lat, bh, bd);
            checks++; if (lat !== 16) $display("FAIL rand_latency in=%0d: got %0d expected 16", value, lat); else passes++;
            expBcd = modelBcd(longint'(value), 5);
            checks++; if (bcdA !== expBcd) $display("FAIL rand_bcdA in=%0d: got %h expected %h", value, bcdA, expBcd); else passes++;
            expSeg = modelSeg(longint'(value), 5, 1'b1);
            checks++; if (segA !== expSeg) $display("FAIL rand_segA in=%0d: got %h expected %h", value, segA, expSeg); else passes++;
            expSeg = modelSeg(longint'(value), 5, 1'b0);
            checks++; if (segB !== expSeg) $display("FAIL rand_segB in=%0d: got %h expected %h", value, segB, expSeg); else passes++;
            expBcd = modelBcd(longint'(value), 4);
            checks++; if (bcdC !== expBcd[15:0]) $display("FAIL rand_bcdC in=%0d: got %h expected %h", value, bcdC, expBcd[15:0]); else passes++;
            expSeg = modelSeg(longint'(value), 4, 1'b1);
            checks++; if (segC !== expSeg[27:0]) $display("FAIL rand_segC in=%0d: got %h expected %h", value, segC, expSeg[27:0]); else passes++;
            checks++; if (ovfC !== modelOvf(longint'(value), 4))
                $display("FAIL rand_ovfC in=%0d: got %b expected %b", value, ovfC, modelOvf(longint'(value), 4)); else passes++;
        end
    endtask

    task automatic test_start_ignored;
        int doneCount, doneEdge;
        logic [19:0] resBcd;
        doneCount = 0;
        doneEdge  = -1;
        resBcd    = '0;
        @(negedge clk);
        start = 1'b1;
        inVal = 16'd500;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 6) begin
                start = 1'b1;
                inVal = 16'd7;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (doneA) begin
                doneCount++;
                doneEdge = e;
                resBcd   = bcdA;
            end
        end
        checks++; if (doneCount !== 1) $display("FAIL ignore_done_count: got %0d expected 1", doneCount); else passes++;
        checks++; if (doneEdge !== 16) $display("FAIL ignore_done_edge: got %0d expected 16", doneEdge); else passes++;
        checks++; if (resBcd !== 20'h00500) $display("FAIL ignore_result: got %h expected 00500", resBcd); else passes++;
    endtask

    task automatic test_back_to_back;
        int lat, bh, gap;
        logic bd;
        doConvert(16'd500, lat, bh, bd);
        checks++; if (bcdA !== 20'h00500) $display("FAIL b2b_first: got %h expected 00500", bcdA); else passes++;
        start = 1'b1;
        inVal = 16'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        gap   = 1;
        checks++; if (busyA !== 1'b1) $display("FAIL b2b_accept_busy: got %b expected 1", busyA); else passes++;
        while (gap < 40 && !doneA) begin
            @(posedge clk);
            #1;
            gap++;
        end
        checks++; if (gap !== 17) $display("FAIL b2b_gap: got %0d expected 17", gap); else passes++;
        checks++; if (bcdA !== 20'h00042) $display("FAIL b2b_bcd: got %h expected 00042", bcdA); else passes++;
        checks++; if (segA !== {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24})
            $display("FAIL b2b_seg: got %h expected %h", segA, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}); else passes++;
    endtask

    task automatic test_reset_mid;
        int lat, bh, spurious;
        logic bd;
        spurious = 0;
        doConvert(16'd4321, lat, bh, bd);
        checks++; if (bcdA !== 20'h04321) $display("FAIL midrst_pre: got %h expected 04321", bcdA); else passes++;
        @(negedge clk);
        start = 1'b1;
        inVal = 16'd54321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (doneA) spurious++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busyA !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busyA); else passes++;
        checks++; if (bcdA !== 20'h0) $display("FAIL midrst_bcd: got %h expected 0", bcdA); else passes++;
        checks++; if (segA !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL midrst_segA: got %h expected %h", segA, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); else passes++;
        checks++; if (segB !== {5{7'h40}}) $display("FAIL midrst_segB: got %h expected %h", segB, {5{7'h40}}); else passes++;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (doneA) spurious++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (doneA || busyA) spurious++;
        end
        checks++; if (spurious !== 0) $display("FAIL midrst_no_done: got %0d events expected 0", spurious); else passes++;
        doConvert(16'd808, lat, bh, bd);
        checks++; if (lat !== 16) $display("FAIL midrst_fresh_latency: got %0d expected 16", lat); else passes++;
        checks++; if (bcdA !== 20'h00808) $display("FAIL midrst_fresh_bcd: got %h expected 00808", bcdA); else passes++;
        checks++; if (segA !== {7'h7F, 7'h7F, 7'h00, 7'h40, 7'h00})
            $display("FAIL midrst_fresh_seg: got %h expected %h", segA, {7'h7F, 7'h7F, 7'h00, 7'h40, 7'h00}); else passes++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_blanking();
        test_overflow();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
